// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath enables per state.
// Define CTRL_RETIRE_CNT_EN to build the retired-instruction pulse and counter; otherwise both are tied to 0.
module multicycle_control_unit #(
    parameter int OPCODE_W = 4,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                jump,
    output logic                link,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src,
    output logic                imm_src,
    output logic [2:0]          alu_op,
    output logic                halt,
    output logic                trap,
    output logic                instr_retired,
    output logic [CNT_W-1:0]    instr_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_MEM     = 3'd4;
    localparam logic [2:0] S_WB      = 3'd5;
    localparam logic [2:0] S_HALTED  = 3'd6;
    localparam logic [2:0] S_TRAPPED = 3'd7;

    localparam logic [3:0] OP_HALT  = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_ADDI  = 4'h3;
    localparam logic [3:0] OP_SUBI  = 4'h4;
    localparam logic [3:0] OP_LSH   = 4'h5;
    localparam logic [3:0] OP_RSH   = 4'h6;
    localparam logic [3:0] OP_JUMP  = 4'h7;
    localparam logic [3:0] OP_JUMPL = 4'h8;
    localparam logic [3:0] OP_BGE   = 4'h9;
    localparam logic [3:0] OP_BLE   = 4'hA;
    localparam logic [3:0] OP_BNE   = 4'hB;
    localparam logic [3:0] OP_LOAD  = 4'hC;
    localparam logic [3:0] OP_STORE = 4'hD;
    localparam logic [3:0] OP_AND   = 4'hE;
    localparam logic [3:0] OP_OR    = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_LSH = 3'd4;
    localparam logic [2:0] ALU_RSH = 3'd5;
    localparam logic [2:0] ALU_GE  = 3'd6;
    localparam logic [2:0] ALU_LE  = 3'd7;

    logic [2:0] state;
    logic [2:0] next_state;
    logic [3:0] op_q;
    logic       upper_nz;
    logic       op_is_alu;
    logic       op_is_mem;

    // Only the low nibble is ever latched; any set upper bit diverts to TRAPPED at decode.
    generate
        if (OPCODE_W > 4) begin : g_upper
            assign upper_nz = |opcode[OPCODE_W-1:4];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign op_is_alu = (op_q inside {OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_LSH, OP_RSH, OP_AND, OP_OR});
    assign op_is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);

    // NOTE: the reset is in the sensitivity list, so asserting rst_n forces IDLE without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            state <= S_IDLE;
            op_q  <= OP_HALT;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                op_q <= opcode[3:0];
            end
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
        next_state = state;
        unique case (state)
            S_IDLE:   next_state = S_FETCH;
            S_FETCH:  if (mem_ready) next_state = S_DECODE;
            S_DECODE: begin
                if (upper_nz)                   next_state = S_TRAPPED;
                else if (opcode[3:0] == OP_HALT) next_state = S_HALTED;
                else                            next_state = S_EXEC;
            end
            S_EXEC: begin
                if (op_is_alu)      next_state = S_WB;
                else if (op_is_mem) next_state = S_MEM;
                else                next_state = S_FETCH;
            end
            S_MEM: begin
                if (mem_ready) next_state = (op_q == OP_STORE) ? S_FETCH : S_WB;
            end
            S_WB:      next_state = S_FETCH;
            S_HALTED:  next_state = S_HALTED;
            S_TRAPPED: next_state = S_TRAPPED;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        link       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        imm_src    = 1'b0;
        alu_op     = ALU_ADD;
        halt       = 1'b0;
        trap       = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  alu_op = ALU_ADD;
                    OP_SUB:  alu_op = ALU_SUB;
                    OP_ADDI: begin alu_op = ALU_ADD; alu_src = 1'b1; imm_src = 1'b1; end
                    OP_SUBI: begin alu_op = ALU_SUB; alu_src = 1'b1; imm_src = 1'b1; end
                    OP_LSH:  alu_op = ALU_LSH;
                    OP_RSH:  alu_op = ALU_RSH;
                    OP_AND:  alu_op = ALU_AND;
                    OP_OR:   alu_op = ALU_OR;
                    OP_BGE:  begin alu_op = ALU_GE; branch = 1'b1; end
                    OP_BLE, OP_BNE: begin alu_op = ALU_LE; branch = 1'b1; end
                    OP_JUMP: begin jump = 1'b1; pc_write = 1'b1; end
                    OP_JUMPL: begin
                        jump      = 1'b1;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        link      = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin alu_op = ALU_ADD; alu_src = 1'b1; imm_src = 1'b1; end
                    default: ;
                endcase
            end
            S_MEM: begin
                // Address stays ALU-computed for the whole wait, so the ALU controls are held too.
                mem_req = 1'b1;
                iord    = 1'b1;
                alu_src = 1'b1;
                imm_src = 1'b1;
                mem_we  = (op_q == OP_STORE);
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (op_q == OP_LOAD);
            end
            S_HALTED:  halt = 1'b1;
            S_TRAPPED: trap = 1'b1;
            default: ;
        endcase
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic retire;

    // HALT retires in DECODE, before its opcode reaches op_q, so it is judged from the live field.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_DECODE: retire = !upper_nz && (opcode[3:0] == OP_HALT);
            S_EXEC:   retire = !op_is_alu && !op_is_mem;
            S_MEM:    retire = mem_ready && (op_q == OP_STORE);
            S_WB:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign instr_retired = retire;
`else
    assign instr_retired = 1'b0;
    assign instr_count   = '0;
`endif

endmodule
